// File: rtl/spi_multi_axis_reader.sv
// spi_multi_axis_reader: SPI mode-0 burst reader packing one bit field per 16-bit channel word.
// Define SPI_READER_SAT_EN to treat words as signed 12-bit values, arithmetic-shifted and saturated.
module spi_multi_axis_reader #(
    parameter int NUM_CH = 3,
    parameter int FIELD_W = 5,
    parameter int FIELD_LSB = 7,
    parameter int CLK_DIV = 2,
    parameter logic [7:0] CMD_BYTE = 8'h0B,
    parameter logic [7:0] START_ADDR = 8'h0E,
    parameter int GAP_CYCLES = 16
) (
    input  logic iclk,
    input  logic rst_n,
    input  logic start,
    input  logic auto_en,
    input  logic miso,
    output logic cs,
    output logic sclk,
    output logic mosi,
    output logic busy,
    output logic data_valid,
    output logic [NUM_CH*FIELD_W-1:0] data_out
);
    localparam int TOTAL = 16 + 16*NUM_CH;
    localparam int RXW = 16*NUM_CH;
    localparam int CMAX = (2*CLK_DIV > GAP_CYCLES) ? 2*CLK_DIV : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int BW = $clog2(TOTAL);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_BIT = CW'(2*CLK_DIV - 1);
    localparam logic [CW-1:0] C_GAP = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(TOTAL - 1);
    localparam logic [BW-1:0] B_TX = BW'(16);
    localparam logic [15:0] TX = {CMD_BYTE, START_ADDR};

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE, GAP} state_t;

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [BW-1:0] bit_idx, bit_n;
    logic [RXW-1:0] rx;
    logic [NUM_CH-1:0][15:0] words;
    logic [NUM_CH*FIELD_W-1:0] fields;
    logic unused_words;

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            rx <= '0;
            data_out <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            rx <= (state == SHIFT && cnt == C_HALF) ? {rx[RXW-2:0], miso} : rx;
            data_out <= (state == CS_HOLD && cnt == C_HALF) ? fields : data_out;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt + 1'b1;
        bit_n = bit_idx;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start || auto_en) state_n = CS_SETUP;
            end
            CS_SETUP: if (cnt == C_HALF) begin
                state_n = SHIFT;
                cnt_n = '0;
                bit_n = '0;
            end
            SHIFT: if (cnt == C_BIT) begin
                cnt_n = '0;
                if (bit_idx == B_LAST) state_n = CS_HOLD;
                else bit_n = bit_idx + 1'b1;
            end
            CS_HOLD: if (cnt == C_HALF) begin
                state_n = DONE;
                cnt_n = '0;
            end
            DONE: begin
                cnt_n = '0;
                state_n = auto_en ? GAP : IDLE;
            end
            GAP: if (cnt == C_GAP) begin
                state_n = CS_SETUP;
                cnt_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // All outputs decode from registered state, so async reset forces them idle immediately.
    assign cs = (state == IDLE) || (state == DONE) || (state == GAP);
    assign sclk = (state == SHIFT) && (cnt > C_HALF);
    assign mosi = (state == CS_SETUP) ? TX[15] :
                  (state == SHIFT && bit_idx < B_TX) ? TX[~bit_idx[3:0]] : 1'b0;
    assign busy = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD) || (state == DONE);
    assign data_valid = (state == DONE);

`ifdef SPI_READER_SAT_EN
    localparam logic signed [15:0] S_MAX = 16'(2**(FIELD_W-1) - 1);
    localparam logic signed [15:0] S_MIN = 16'(-(2**(FIELD_W-1)));
    logic [NUM_CH-1:0][15:0] sh;
    always_comb begin
        words = '0;
        sh = '0;
        fields = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            words[c] = {rx[RXW-9-16*c -: 8], rx[RXW-1-16*c -: 8]};
            sh[c] = 16'($signed({{4{words[c][11]}}, words[c][11:0]}) >>> FIELD_LSB);
            fields[(NUM_CH-1-c)*FIELD_W +: FIELD_W] =
                ($signed(sh[c]) > S_MAX) ? S_MAX[FIELD_W-1:0] :
                ($signed(sh[c]) < S_MIN) ? S_MIN[FIELD_W-1:0] : sh[c][FIELD_W-1:0];
        end
    end
`else
    always_comb begin
        words = '0;
        fields = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            words[c] = {rx[RXW-9-16*c -: 8], rx[RXW-1-16*c -: 8]};
            fields[(NUM_CH-1-c)*FIELD_W +: FIELD_W] = words[c][FIELD_LSB +: FIELD_W];
        end
    end
`endif

    assign unused_words = ^words;
endmodule

// File: tb/tb_spi_multi_axis_reader.sv
// tb_spi_multi_axis_reader: directed vector bench with behavioural SPI sensor models.
module tb_spi_multi_axis_reader;
    logic iclk = 1'b0, rst_n = 1'b0, start = 1'b0, auto_en = 1'b0, start2 = 1'b0;
    logic cs, sclk, mosi, busy, data_valid, miso;
    logic [14:0] data_out;
    logic cs2, sclk2, mosi2, busy2, dv2, miso2;
    logic [7:0] do2;
    int checks = 0, failures = 0;

    always #5 iclk = ~iclk;

    spi_multi_axis_reader dut (
        .iclk(iclk), .rst_n(rst_n), .start(start), .auto_en(auto_en), .miso(miso),
        .cs(cs), .sclk(sclk), .mosi(mosi), .busy(busy), .data_valid(data_valid), .data_out(data_out)
    );

    spi_multi_axis_reader #(.NUM_CH(2), .FIELD_W(4), .CLK_DIV(1)) dut2 (
        .iclk(iclk), .rst_n(rst_n), .start(start2), .auto_en(1'b0), .miso(miso2),
        .cs(cs2), .sclk(sclk2), .mosi(mosi2), .busy(busy2), .data_valid(dv2), .data_out(do2)
    );

    logic [15:0] wx = 0, wy = 0, wz = 0, wa = 16'h07FF, wb = 16'h0F80;
    logic [47:0] rxs;
    logic [31:0] rxs2;
    assign rxs = {wx[7:0], wx[15:8], wy[7:0], wy[15:8], wz[7:0], wz[15:8]};
    assign rxs2 = {wa[7:0], wa[15:8], wb[7:0], wb[15:8]};

    int ecnt = 0, last_edges = 0, ecnt2 = 0;
    logic sclk_q = 0, sclk2_q = 0, mrest = 0, last_mrest = 0;
    logic [15:0] mcap = 0, last_mcap = 0;

    // Sensor: edges counted at negedge iclk, so miso for bit k is stable well before the DUT samples it.
    always @(negedge iclk) begin
        if (cs) begin
            if (ecnt != 0) begin
                last_edges = ecnt;
                last_mcap = mcap;
                last_mrest = mrest;
            end
            ecnt = 0;
            mcap = 0;
            mrest = 0;
        end else if (sclk && !sclk_q) begin
            if (ecnt < 16) mcap = {mcap[14:0], mosi};
            else mrest = mrest | mosi;
            ecnt++;
        end
        sclk_q = sclk;
        if (cs2) ecnt2 = 0;
        else if (sclk2 && !sclk2_q) ecnt2++;
        sclk2_q = sclk2;
    end

    assign miso = (ecnt >= 16 && ecnt < 64) ? rxs[63-ecnt] : 1'b0;
    assign miso2 = (ecnt2 >= 16 && ecnt2 < 48) ? rxs2[47-ecnt2] : 1'b0;

    typedef struct {
        logic [15:0] x, y, z;
        logic [14:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!data_valid && n < 2000) begin
            @(negedge iclk);
            n++;
        end
        if (!data_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic kick();
        @(negedge iclk);
        start = 1'b1;
        @(posedge iclk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(output int n);
        kick();
        @(negedge iclk);
        chk("busy_rise", {busy, cs}, 2'b10);
        wait_valid(n);
    endtask

    int n, g, vcnt, bad;
    logic [7:0] exp2;

    initial begin
        vecs[0] = '{16'h5555, 16'hAAAA, 16'h5555, 15'h2AAA};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0100, 15'h0002};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'h0080, 15'h7C01};
        vecs[3] = '{16'h0F80, 16'h0780, 16'h0000, 15'h7DE0};
        vecs[4] = '{16'h1234, 16'h5678, 16'h9ABC, 15'h1195};
`ifdef SPI_READER_SAT_EN
        exp2 = 8'h7F;
`else
        exp2 = 8'hFF;
`endif
        repeat (2) @(negedge iclk);
        chk("reset_outs", {cs, sclk, mosi, busy, data_valid}, 5'b10000);
        chk("reset_data", data_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge iclk);

        for (int i = 0; i < 5; i++) begin
            wx = vecs[i].x; wy = vecs[i].y; wz = vecs[i].z;
            run_frame(n);
            chk($sformatf("data_out[%0d]", i), data_out, vecs[i].exp);
            if (i == 0) chk("latency", n, 261);
            chk("busy_at_valid", {busy, cs}, 2'b11);
            @(negedge iclk);
            chk("busy_drop", {busy, data_valid}, 2'b00);
            repeat (3) @(negedge iclk);
            chk("sclk_edges", last_edges, 64);
            chk("mosi_cmd_addr", last_mcap, 16'h0B0E);
            chk("mosi_rx_zero", last_mrest, 0);
        end

        wx = vecs[0].x; wy = vecs[0].y; wz = vecs[0].z;
        @(negedge iclk);
        auto_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_valid(n);
            chk($sformatf("auto_data[%0d]", f), data_out, vecs[f].exp);
            if (f < 2) begin
                wx = vecs[f+1].x; wy = vecs[f+1].y; wz = vecs[f+1].z;
                g = 0;
                while (cs && g < 100) begin
                    g++;
                    @(negedge iclk);
                end
                chk("auto_gap_ge16", g >= 16, 1);
                if (f == 1) begin
                    repeat (100) @(negedge iclk);
                    auto_en = 1'b0;
                end else @(negedge iclk);
            end
        end
        vcnt = 0; bad = 0;
        repeat (300) begin
            @(negedge iclk);
            if (data_valid) vcnt++;
            if (!cs || busy) bad++;
        end
        chk("auto_stop_valids", vcnt, 0);
        chk("auto_stop_idle", bad, 0);

        wx = vecs[3].x; wy = vecs[3].y; wz = vecs[3].z;
        kick();
        g = 0;
        while (ecnt < 30 && g < 1000) begin
            @(negedge iclk);
            g++;
        end
        chk("reach_bit30", ecnt, 30);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs", {cs, sclk, mosi, busy, data_valid}, 5'b10000);
        chk("midreset_data", data_out, 0);
        @(negedge iclk);
        rst_n = 1'b1;
        wx = vecs[4].x; wy = vecs[4].y; wz = vecs[4].z;
        run_frame(n);
        chk("post_reset_data", data_out, vecs[4].exp);
        chk("post_reset_latency", n, 261);

        wx = vecs[3].x; wy = vecs[3].y; wz = vecs[3].z;
        kick();
        repeat (50) @(negedge iclk);
        start = 1'b1;
        @(posedge iclk);
        #1 start = 1'b0;
        vcnt = 0;
        repeat (600) begin
            @(negedge iclk);
            if (data_valid) begin
                vcnt++;
                chk("busy_start_data", data_out, vecs[3].exp);
            end
        end
        chk("busy_start_valids", vcnt, 1);

        @(negedge iclk);
        start2 = 1'b1;
        @(posedge iclk);
        #1 start2 = 1'b0;
        n = 1;
        @(negedge iclk);
        while (!dv2 && n < 500) begin
            @(negedge iclk);
            n++;
        end
        chk("ch2_latency", n, 99);
        chk("ch2_data", do2, exp2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
